// File: rtl/led_blink_avs_responder.sv
// led_blink_avs_responder
//   Avalon-MM responder on the HPS lightweight bridge that drives the board
//   LEDs. Software programs CTRL/PERIOD/PATTERN; the engine then blinks the
//   pattern (mode 0) or rotates it left (mode 1) once every PERIOD cycles and
//   counts the ticks in STATUS[31:16].
// Ports
//   clk, reset           fabric clock, synchronous active-high reset
//   avs_address          0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS
//   avs_read/avs_write   one-cycle strobes, no waitrequest
//   avs_writedata        write data
//   avs_readdata         read data, zero unless avs_readdatavalid
//   avs_readdatavalid    one-cycle response, fixed latency 1
//   led_out              LED drive, 1 = lit
// Handshake: a read sampled at edge E returns its data with
//   avs_readdatavalid = 1 for the single cycle after E. The data is captured
//   from the registers as they were before any write sampled at the same E.
module led_blink_avs_responder #(
  parameter int                    LED_WIDTH       = 4,
  parameter int                    PERIOD_WIDTH    = 26,
  parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD  = 26'd25000000,
  parameter logic [LED_WIDTH-1:0]  DEFAULT_PATTERN = 4'b0101
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [LED_WIDTH-1:0] led_out
);

  // The engine state is the enable bit of CTRL.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [LED_WIDTH-1:0]    pattern_q, pattern_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [LED_WIDTH-1:0]    work_q, work_d;
  logic [15:0]             tick_q, tick_d;

  logic                    wr_ctrl, wr_period, wr_pattern, wr_status;
  logic [PERIOD_WIDTH-1:0] last_cnt;
  logic                    tick;
  logic [31:0]             rd_mux;
  logic                    unused_wdata;

  assign wr_ctrl    = avs_write && (avs_address == 2'd0);
  assign wr_period  = avs_write && (avs_address == 2'd1);
  assign wr_pattern = avs_write && (avs_address == 2'd2);
  assign wr_status  = avs_write && (avs_address == 2'd3);

  // PERIOD = 0 behaves as 1, so the terminal count is 0 in both cases.
  assign last_cnt = (period_q == '0) ? '0 : period_q - 1'b1;
  assign tick     = (state_q == RUN) && (cnt_q == last_cnt);

  // High write-data bits are don't-care for every register.
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    work_d    = work_q;
    tick_d    = tick_q;

    // Enabling while already running leaves the engine untouched; only mode
    // changes, because the IDLE branch below is what (re)starts the engine.
    if (wr_ctrl) begin
      state_d = avs_writedata[0] ? RUN : IDLE;
      mode_d  = avs_writedata[1];
    end
    if (wr_period)  period_d  = avs_writedata[PERIOD_WIDTH-1:0];
    if (wr_pattern) pattern_d = avs_writedata[LED_WIDTH-1:0];

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b1;
        work_d  = pattern_q;
      end
      RUN: begin
        if (tick) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          work_d  = (work_q << 1) | (work_q >> (LED_WIDTH - 1));
          tick_d  = (tick_q == 16'hFFFF) ? tick_q : tick_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (wr_period) cnt_d = '0;
      end
      default: ;
    endcase

    // Bus writes take priority over a coincident tick.
    if (wr_pattern) work_d = avs_writedata[LED_WIDTH-1:0];
    if (wr_status)  tick_d = '0;
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux[1:0] = {mode_q, state_q == RUN};
      2'd1: rd_mux[PERIOD_WIDTH-1:0] = period_q;
      2'd2: rd_mux[LED_WIDTH-1:0] = pattern_q;
      2'd3: begin
        rd_mux[31:16] = tick_q;
        rd_mux[0]     = (state_q == RUN);
      end
      default: ;
    endcase
  end

  // LED decode uses registered state only.
  always_comb begin
    led_out = pattern_q;
    if (state_q == RUN) begin
      if (mode_q) led_out = work_q;
      else        led_out = phase_q ? pattern_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      mode_q            <= 1'b0;
      period_q          <= DEFAULT_PERIOD;
      pattern_q         <= DEFAULT_PATTERN;
      cnt_q             <= '0;
      phase_q           <= 1'b1;
      work_q            <= DEFAULT_PATTERN;
      tick_q            <= '0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
    end else begin
      state_q           <= state_d;
      mode_q            <= mode_d;
      period_q          <= period_d;
      pattern_q         <= pattern_d;
      cnt_q             <= cnt_d;
      phase_q           <= phase_d;
      work_q            <= work_d;
      tick_q            <= tick_d;
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : '0;
    end
  end

endmodule
